// File: rtl/xgmii_to_axis_rx.sv
// Receive converter: 64-bit XGMII to AXI4-Stream, strips /S/ and repacks frame bytes into 8-byte beats.
// Optional macro XGMII_TO_AXIS_LANE4_START_EN additionally accepts /S/ in lane 4.
module xgmii_to_axis_rx (
  input  logic        clock,
  input  logic        areset,
  input  logic [63:0] xgmii_d,
  input  logic [7:0]  xgmii_c,
  output logic [63:0] maxis_tdata,
  output logic [7:0]  maxis_tkeep,
  output logic        maxis_tvalid,
  output logic        maxis_tlast,
  output logic        maxis_tuser
);
  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;

  typedef enum logic [1:0] {IDLE, FRAME, TAIL} state_t;

  state_t      state_q, state_d;
  logic [2:0]  off_q, off_d;
  logic [55:0] hold_q, hold_d;
  logic [7:0]  tail_keep_q, tail_keep_d;
  logic        tail_err_q, tail_err_d;
  logic [63:0] tdata_q, tdata_d;
  logic [7:0]  tkeep_q, tkeep_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;

  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

  function automatic logic [55:0] top_bytes(input logic [63:0] w, input logic [2:0] o);
    logic [6:0] sh;
    sh = {4'd8 - {1'b0, o}, 3'b000};
    return 56'(w >> sh);
  endfunction

  logic        start_hit;
  logic [2:0]  start_off;
  logic        ctrl_any;
  logic [2:0]  ctrl_lane;
  logic [7:0]  end_char;
  logic [3:0]  n_tot;
  logic [119:0] ext;

  always_comb begin
    start_hit = 1'b0;
    start_off = 3'd7;
    if (xgmii_c[0] && xgmii_d[7:0] == CH_START) begin
      start_hit = 1'b1;
      start_off = 3'd7;
    end
`ifdef XGMII_TO_AXIS_LANE4_START_EN
    else if (xgmii_c[4] && xgmii_d[39:32] == CH_START) begin
      start_hit = 1'b1;
      start_off = 3'd3;
    end
`endif
  end

  always_comb begin
    ctrl_any  = |xgmii_c;
    ctrl_lane = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (xgmii_c[i]) ctrl_lane = 3'(i);
    end
  end

  // Held bytes sit below the new word; bits above 63 are the bytes carried into the next beat.
  assign ext      = ({56'd0, xgmii_d} << {off_q, 3'b000}) | {64'd0, hold_q};
  assign end_char = xgmii_d[{ctrl_lane, 3'b000} +: 8];
  assign n_tot    = {1'b0, off_q} + {1'b0, ctrl_lane};

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    hold_d      = hold_q;
    tail_keep_d = tail_keep_q;
    tail_err_d  = tail_err_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_hit) begin
          state_d = FRAME;
          off_d   = start_off;
          hold_d  = top_bytes(xgmii_d, start_off);
        end
      end
      FRAME: begin
        tvalid_d = 1'b1;
        tdata_d  = ext[63:0];
        tkeep_d  = 8'hFF;
        hold_d   = ext[119:64];
        if (ctrl_any) begin
          if (n_tot <= 4'd8) begin
            tkeep_d = keep_mask(n_tot);
            tlast_d = 1'b1;
            tuser_d = (end_char != CH_TERM);
            state_d = IDLE;
          end else begin
            tail_keep_d = keep_mask(4'(n_tot - 4'd8));
            tail_err_d  = (end_char != CH_TERM);
            state_d     = TAIL;
          end
        end
      end
      TAIL: begin
        tvalid_d = 1'b1;
        tlast_d  = 1'b1;
        tuser_d  = tail_err_q;
        tdata_d  = {8'd0, hold_q};
        tkeep_d  = tail_keep_q;
        state_d  = IDLE;
        // The tail beat only uses held state, so a new /S/ here can be taken immediately.
        if (start_hit) begin
          state_d = FRAME;
          off_d   = start_off;
          hold_d  = top_bytes(xgmii_d, start_off);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (areset) begin
      state_q  <= IDLE;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      tdata_q  <= 64'd0;
      tkeep_q  <= 8'hFF;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
    end
  end

  always_ff @(posedge clock) begin
    off_q       <= off_d;
    hold_q      <= hold_d;
    tail_keep_q <= tail_keep_d;
    tail_err_q  <= tail_err_d;
  end

  assign maxis_tdata  = tdata_q;
  assign maxis_tkeep  = tkeep_q;
  assign maxis_tvalid = tvalid_q;
  assign maxis_tlast  = tlast_q;
  assign maxis_tuser  = tuser_q;
endmodule

// File: tb/tb_xgmii_to_axis_rx.sv
// Bench for xgmii_to_axis_rx: directed vectors plus random frames against a byte-queue reference model.
module tb_xgmii_to_axis_rx;
`ifdef XGMII_TO_AXIS_LANE4_START_EN
  localparam bit LANE4 = 1'b1;
`else
  localparam bit LANE4 = 1'b0;
`endif
  localparam logic [63:0] IDLE_D = 64'h0707_0707_0707_0707;

  logic        clock = 1'b0;
  logic        areset;
  logic [63:0] xgmii_d;
  logic [7:0]  xgmii_c;
  logic [63:0] maxis_tdata;
  logic [7:0]  maxis_tkeep;
  logic        maxis_tvalid;
  logic        maxis_tlast;
  logic        maxis_tuser;

  always #5 clock = ~clock;

  xgmii_to_axis_rx dut (
    .clock(clock), .areset(areset), .xgmii_d(xgmii_d), .xgmii_c(xgmii_c),
    .maxis_tdata(maxis_tdata), .maxis_tkeep(maxis_tkeep), .maxis_tvalid(maxis_tvalid),
    .maxis_tlast(maxis_tlast), .maxis_tuser(maxis_tuser)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: frame bytes queue up and leave in 8-byte chunks; beat vector = {valid,last,user,keep,data}.
  logic [7:0]  mq[$];
  bit          m_in_frame = 1'b0;
  bit          m_tail_pend = 1'b0;
  logic [74:0] m_tail_vec;
  logic [74:0] e_vec;
  logic [63:0] sd[$];
  logic [7:0]  sc[$];

  function automatic logic [74:0] obs_vec();
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{maxis_tkeep[i]}};
    if (maxis_tvalid) return {1'b1, maxis_tlast, maxis_tuser, maxis_tkeep, maxis_tdata & m};
    return {1'b0, maxis_tlast, maxis_tuser, 8'h00, 64'h0};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_in_frame  = 1'b0;
    m_tail_pend = 1'b0;
  endtask

  task automatic pop_beat(input int n, input bit last, input bit err, output logic [74:0] v);
    logic [63:0] dat;
    logic [7:0]  k;
    dat = '0;
    k   = '0;
    for (int i = 0; i < n; i++) begin
      dat[8*i +: 8] = mq.pop_front();
      k[i] = 1'b1;
    end
    v = {1'b1, last, err, k, dat};
  endtask

  task automatic step(input logic [63:0] d, input logic [7:0] c);
    int   t;
    bit   may_start;
    logic err;
    e_vec = '0;
    may_start = 1'b1;
    if (m_tail_pend) begin
      e_vec = m_tail_vec;
      m_tail_pend = 1'b0;
    end else if (m_in_frame) begin
      may_start = 1'b0;
      t = 8;
      for (int i = 7; i >= 0; i--) if (c[i]) t = i;
      for (int i = 0; i < t; i++) mq.push_back(d[8*i +: 8]);
      if (t == 8) begin
        if (mq.size() >= 8) pop_beat(8, 1'b0, 1'b0, e_vec);
      end else begin
        err = (d[8*t +: 8] != 8'hFD);
        m_in_frame = 1'b0;
        if (mq.size() <= 8) pop_beat(mq.size(), 1'b1, err, e_vec);
        else begin
          pop_beat(8, 1'b0, 1'b0, e_vec);
          pop_beat(mq.size(), 1'b1, err, m_tail_vec);
          m_tail_pend = 1'b1;
        end
      end
    end
    if (may_start) begin
      if (c[0] && d[7:0] == 8'hFB) begin
        for (int i = 1; i < 8; i++) mq.push_back(d[8*i +: 8]);
        m_in_frame = 1'b1;
      end else if (LANE4 && c[4] && d[39:32] == 8'hFB) begin
        for (int i = 5; i < 8; i++) mq.push_back(d[8*i +: 8]);
        m_in_frame = 1'b1;
      end
    end
    xgmii_d = d;
    xgmii_c = c;
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic [63:0] d, input logic [7:0] c);
    sd.push_back(d);
    sc.push_back(c);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    xgmii_d = IDLE_D;
    xgmii_c = 8'hFF;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({maxis_tvalid, maxis_tlast, maxis_tuser} !== 3'b000)
      $display("FAIL reset_ctrl: got vlu=%b want 000", {maxis_tvalid, maxis_tlast, maxis_tuser});
    else passes++;
    checks++;
    if (maxis_tdata !== 64'h0 || maxis_tkeep !== 8'hFF)
      $display("FAIL reset_data: got d=%h k=%h want d=0 k=ff", maxis_tdata, maxis_tkeep);
    else passes++;
    areset = 1'b0;
    for (int i = 0; i < 4; i++) add(IDLE_D, 8'hFF);
    foreach (sd[i]) begin
      step(sd[i], sc[i]);
      checks++;
      if (obs_vec() !== e_vec) $display("FAIL idle word %0d: got %h want %h", i, obs_vec(), e_vec);
      else passes++;
    end
    sd.delete(); sc.delete();
  endtask

  task automatic test_directed();
    step(64'h0605_0403_0201_00FB, 8'h01);
    checks++;
    if (maxis_tvalid !== 1'b0) $display("FAIL single_start: got tvalid=%b want 0", maxis_tvalid);
    else passes++;
    step(64'h0707_0707_0707_FD07, 8'hFE);
    checks++;
    if ({maxis_tvalid, maxis_tlast, maxis_tuser, maxis_tkeep, maxis_tdata} !==
        {3'b110, 8'hFF, 64'h0706_0504_0302_0100})
      $display("FAIL single_beat: got v%b l%b u%b k%h d%h want v1 l1 u0 kff d0706050403020100",
               maxis_tvalid, maxis_tlast, maxis_tuser, maxis_tkeep, maxis_tdata);
    else passes++;
    add(IDLE_D, 8'hFF);
    add(64'h0605_0403_0201_00FB, 8'h01);
    add(64'hFD0D_0C0B_0A09_0807, 8'h80);
    add(IDLE_D, 8'hFF);
    add(IDLE_D, 8'hFF);
    add(64'h0605_0403_0201_00FB, 8'h01);
    add(64'h0707_0707_0707_07FE, 8'hFF);
    add(IDLE_D, 8'hFF);
    add(64'h0201_00FB_0707_0707, 8'h1F);
    add(64'h0A09_0807_0605_0403, 8'h00);
    add(64'h07FD_100F_0E0D_0C0B, 8'hC0);
    add(IDLE_D, 8'hFF);
    add(64'h0605_0403_0201_00FB, 8'h01);
    add(64'h0707_FB07_0707_FD11, 8'hFE);
    add(64'h1111_1111_1111_1111, 8'h00);
    add(64'h0707_0707_0707_07FD, 8'hFF);
    add(IDLE_D, 8'hFF);
    foreach (sd[i]) begin
      step(sd[i], sc[i]);
      checks++;
      if (obs_vec() !== e_vec) $display("FAIL directed word %0d: got %h want %h", i, obs_vec(), e_vec);
      else passes++;
    end
    sd.delete(); sc.delete();
  endtask

  task automatic test_back_to_back();
    add(64'h1716_1514_1312_11FB, 8'h01);
    add(64'h1F1E_1D1C_1B1A_1918, 8'h00);
    add(64'h0707_FD24_2322_2120, 8'hE0);
    add(64'h3736_3534_3332_31FB, 8'h01);
    add(64'h0707_0707_0707_07FD, 8'hFF);
    add(64'h4746_4544_4342_41FB, 8'h01);
    add(64'h0707_0707_07FD_4948, 8'hFC);
    add(IDLE_D, 8'hFF);
    add(IDLE_D, 8'hFF);
    foreach (sd[i]) begin
      step(sd[i], sc[i]);
      checks++;
      if (obs_vec() !== e_vec) $display("FAIL b2b word %0d: got %h want %h", i, obs_vec(), e_vec);
      else passes++;
    end
    sd.delete(); sc.delete();
  endtask

  task automatic test_reset_mid_frame();
    step(64'h5756_5554_5352_51FB, 8'h01);
    step(64'h5F5E_5D5C_5B5A_5958, 8'h00);
    areset = 1'b1;
    xgmii_d = 64'h6766_6564_6362_6160;
    xgmii_c = 8'h00;
    model_reset();
    @(posedge clock);
    #1;
    checks++;
    if ({maxis_tvalid, maxis_tlast, maxis_tuser, maxis_tkeep, maxis_tdata} !== {3'b000, 8'hFF, 64'h0})
      $display("FAIL midreset_out: got v%b l%b u%b k%h d%h want v0 l0 u0 kff d0",
               maxis_tvalid, maxis_tlast, maxis_tuser, maxis_tkeep, maxis_tdata);
    else passes++;
    areset = 1'b0;
    add(64'h6F6E_6D6C_6B6A_6968, 8'h00);
    add(64'h0707_0707_07FD_7170, 8'hFC);
    add(IDLE_D, 8'hFF);
    add(64'h8786_8584_8382_81FB, 8'h01);
    add(64'h8F8E_8D8C_8B8A_8988, 8'h00);
    add(64'h0707_0707_0707_FD90, 8'hFE);
    add(IDLE_D, 8'hFF);
    foreach (sd[i]) begin
      step(sd[i], sc[i]);
      checks++;
      if (obs_vec() !== e_vec) $display("FAIL midreset word %0d: got %h want %h", i, obs_vec(), e_vec);
      else passes++;
    end
    sd.delete(); sc.delete();
  endtask

  task automatic test_random();
    logic [7:0] ld[$];
    bit         lc[$];
    logic [63:0] d;
    logic [7:0]  c;
    for (int f = 0; f < 80; f++) begin
      int gap = int'($urandom_range(0, 2));
      bit l4  = 1'($urandom_range(0, 1));
      int len = (l4 ? 3 : 7) + int'($urandom_range(0, 30));
      for (int g = 0; g < 8 * gap; g++) begin ld.push_back(8'h07); lc.push_back(1'b1); end
      if (l4) for (int g = 0; g < 4; g++) begin ld.push_back(8'h07); lc.push_back(1'b1); end
      ld.push_back(8'hFB); lc.push_back(1'b1);
      for (int b = 0; b < len; b++) begin ld.push_back(8'($urandom)); lc.push_back(1'b0); end
      ld.push_back(($urandom_range(0, 3) == 0) ? 8'hFE : 8'hFD); lc.push_back(1'b1);
      while (ld.size() % 8 != 0) begin ld.push_back(8'h07); lc.push_back(1'b1); end
    end
    for (int g = 0; g < 16; g++) begin ld.push_back(8'h07); lc.push_back(1'b1); end
    for (int w = 0; w < ld.size() / 8; w++) begin
      for (int l = 0; l < 8; l++) begin
        d[8*l +: 8] = ld[8*w + l];
        c[l] = lc[8*w + l];
      end
      add(d, c);
    end
    foreach (sd[i]) begin
      step(sd[i], sc[i]);
      checks++;
      if (obs_vec() !== e_vec) $display("FAIL random word %0d: got %h want %h", i, obs_vec(), e_vec);
      else passes++;
    end
    sd.delete(); sc.delete();
  endtask

  initial begin
    areset = 1'b1;
    xgmii_d = IDLE_D;
    xgmii_c = 8'hFF;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
